// File: rtl/enc_quad_frontend.sv
// enc_quad_frontend -- quadrature encoder input stage.
//
// Synchronises and glitch-filters ENC_A/ENC_B. Decodes them x4 into a
// two's-complement position count, a step/dir pulse pair and a sticky
// illegal-transition flag.
//
// Optional feature macro: ENC_INDEX_EN
//   When defined, an index channel gets the same sync+filter path. A filtered
//   rising edge latches the position and can zero it.
//
// Parameters
//   FILTER_LEN  cycles a synced input must differ before it is accepted (1..15)
//   POS_BITS    position counter width
//
// Ports
//   wb_clk_i    system clock
//   resetn      synchronous active-low reset
//   enc_a_i     raw channel A (async)
//   enc_b_i     raw channel B (async)
//   invert_i    swap count direction
//   clear_i     strobe: position_o <= 0
//   err_clr_i   strobe: clear err_o
//   idx_i       raw index channel                [ENC_INDEX_EN]
//   idx_zero_i  zero position on index           [ENC_INDEX_EN]
//   idx_pos_o   position latched at index        [ENC_INDEX_EN]
//   idx_seen_o  sticky index seen, clear_i clears [ENC_INDEX_EN]
//   position_o  accumulated position
//   step_o      1-cycle pulse per accepted edge
//   dir_o       direction of last accepted edge (1 = +)
//   err_o       sticky illegal (double-bit) transition
//   filt_a_o    filtered A (debug)
//   filt_b_o    filtered B (debug)

// One channel: 2-FF synchroniser followed by a persistence filter.
module enc_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic wb_clk_i,
  input  logic resetn,
  input  logic raw_i,
  output logic filt_o
);
  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  logic       s1, s2;
  logic [3:0] cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      filt_o <= 1'b0;
    end else begin
      s1 <= raw_i;
      s2 <= s1;
      // Any agreement restarts the run, so short pulses never get through.
      if (s2 != filt_o) begin
        if (cnt == LAST) begin
          filt_o <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module enc_quad_frontend #(
  parameter int FILTER_LEN = 4,
  parameter int POS_BITS   = 32
) (
  input  logic                wb_clk_i,
  input  logic                resetn,
  input  logic                enc_a_i,
  input  logic                enc_b_i,
  input  logic                invert_i,
  input  logic                clear_i,
  input  logic                err_clr_i,
`ifdef ENC_INDEX_EN
  input  logic                idx_i,
  input  logic                idx_zero_i,
  output logic [POS_BITS-1:0] idx_pos_o,
  output logic                idx_seen_o,
`endif
  output logic [POS_BITS-1:0] position_o,
  output logic                step_o,
  output logic                dir_o,
  output logic                err_o,
  output logic                filt_a_o,
  output logic                filt_b_o
);
`ifdef ENC_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  // Pad-to-filtered latency plus one, so prev is settled before decoding.
  localparam int PRIME_N = FILTER_LEN + 3;

  logic [NCH-1:0] raw, filt;

`ifdef ENC_INDEX_EN
  assign raw = {idx_i, enc_b_i, enc_a_i};
`else
  assign raw = {enc_b_i, enc_a_i};
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    enc_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .wb_clk_i (wb_clk_i),
      .resetn   (resetn),
      .raw_i    (raw[c]),
      .filt_o   (filt[c])
    );
  end

  assign filt_a_o = filt[0];
  assign filt_b_o = filt[1];

  // Priming: holds off decoding until the filters reflect the real pads.
  logic [4:0] prime_cnt;
  logic       primed;

  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_cnt == 5'(PRIME_N - 1)) primed <= 1'b1;
      else                              prime_cnt <= prime_cnt + 5'd1;
    end
  end

  // Decoder. Forward order 00->10->11->01->00 (A leads B).
  logic [1:0]          cur, prev;
  logic                fwd, rev, illegal, step, up, zero;
  logic [POS_BITS-1:0] pos_cnt, pos_next;

  assign cur = {filt[0], filt[1]};

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
      default: ;
    endcase
  end

  assign illegal = primed && ((prev ^ cur) == 2'b11);
  assign step    = primed && (fwd || rev);
  assign up      = fwd ^ invert_i;
  assign pos_cnt = !step ? position_o
                 : up    ? position_o + POS_BITS'(1)
                         : position_o - POS_BITS'(1);

`ifdef ENC_INDEX_EN
  logic idx_d, idx_rise;
  assign idx_rise = primed && filt[2] && !idx_d;
  assign zero     = idx_rise && idx_zero_i;

  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      idx_d      <= 1'b0;
      idx_pos_o  <= '0;
      idx_seen_o <= 1'b0;
    end else begin
      idx_d <= filt[2];
      if (idx_rise) begin
        idx_pos_o  <= pos_cnt;
        idx_seen_o <= 1'b1;
      end else if (clear_i) begin
        idx_seen_o <= 1'b0;
      end
    end
  end
`else
  assign zero = 1'b0;
`endif

  // clear_i overrides the count but the step pulse still goes out.
  assign pos_next = (clear_i || zero) ? '0 : pos_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      prev       <= 2'b00;
      position_o <= '0;
      step_o     <= 1'b0;
      dir_o      <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      // prev always follows cur; while unprimed this just absorbs idle levels.
      prev       <= cur;
      position_o <= pos_next;
      step_o     <= step;
      if (step) dir_o <= up;
      if (illegal)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_enc_quad_frontend.sv
module tb_enc_quad_frontend;
  localparam int FL = 4;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          a = 1'b1, b = 1'b1, inv = 1'b0, clr = 1'b0, eclr = 1'b0;
  logic [PB-1:0] position;
  logic          step, dir, err, fa, fb;
`ifdef ENC_INDEX_EN
  logic          idx = 1'b0, idx_zero = 1'b0;
  logic [PB-1:0] idx_pos;
  logic          idx_seen;
`endif

  enc_quad_frontend #(.FILTER_LEN(FL), .POS_BITS(PB)) dut (
    .wb_clk_i   (clk),
    .resetn     (resetn),
    .enc_a_i    (a),
    .enc_b_i    (b),
    .invert_i   (inv),
    .clear_i    (clr),
    .err_clr_i  (eclr),
`ifdef ENC_INDEX_EN
    .idx_i      (idx),
    .idx_zero_i (idx_zero),
    .idx_pos_o  (idx_pos),
    .idx_seen_o (idx_seen),
`endif
    .position_o (position),
    .step_o     (step),
    .dir_o      (dir),
    .err_o      (err),
    .filt_a_o   (fa),
    .filt_b_o   (fb)
  );

  always #5 clk = ~clk;

  int nsteps = 0;
  always @(negedge clk) if (step === 1'b1) nsteps++;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Quadrature phase index: forward motion is +1 mod 4.
  function automatic int ph_of(input logic pa, input logic pb);
    case ({pa, pb})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic move(input int d, input int wait_n);
    {a, b} = ab_of((ph_of(a, b) + d) % 4);
    repeat (wait_n) tick();
  endtask

  task automatic wait_filt(input logic [1:0] want);
    int n = 0;
    while ({fa, fb} !== want && n < 20) begin
      tick();
      n++;
    end
    chk("filt_wait", {30'd0, fa, fb}, {30'd0, want});
  endtask

  typedef struct {
    logic       a, b, inv;
    logic [7:0] pos;
    logic       dir, err;
    int         steps;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int base, ph, d, mpos, msteps;
    logic mdir, merr, rose;

    // Pads 11 start: 8 forward edges, 8 more with invert, then a double-bit jump.
    begin
      logic [1:0] seq [8];
      seq = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
      for (int i = 0; i < 8; i++) begin
        tbl[i]   = '{seq[i][1], seq[i][0], 1'b0, 8'(i + 1), 1'b1, 1'b0, i + 1};
        tbl[i+8] = '{seq[i][1], seq[i][0], 1'b1, 8'(7 - i), 1'b0, 1'b0, i + 9};
      end
      tbl[16] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 16};
    end

    // Reset with pads idle high.
    repeat (3) tick();
    chk("rst_pos", 32'(position), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_filt", {30'd0, fa, fb}, 0);
    resetn = 1'b1;
    repeat (20) tick();
    chk("prime_steps", nsteps, 0);
    chk("prime_pos", 32'(position), 0);
    chk("prime_err", 32'(err), 0);
    chk("prime_filt", {30'd0, fa, fb}, 32'b11);

    base = nsteps;
    for (int i = 0; i < 17; i++) begin
      a = tbl[i].a; b = tbl[i].b; inv = tbl[i].inv;
      repeat (10) tick();
      chk($sformatf("vec%0d_pos", i), 32'(position), 32'(tbl[i].pos));
      chk($sformatf("vec%0d_dir", i), 32'(dir), 32'(tbl[i].dir));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_steps", i), nsteps - base, tbl[i].steps);
    end

    // Glitches on A at state 00: 3 cycles dropped, 4 cycles accepted.
    rose = 1'b0;
    a = 1'b1;
    repeat (3) tick();
    a = 1'b0;
    repeat (10) begin tick(); if (fa) rose = 1'b1; end
    chk("glitch3_filt", 32'(rose), 0);
    chk("glitch3_pos", 32'(position), 0);
    base = nsteps;
    a = 1'b1;
    repeat (4) begin tick(); if (fa) rose = 1'b1; end
    a = 1'b0;
    repeat (14) begin tick(); if (fa) rose = 1'b1; end
    chk("pulse4_filt", 32'(rose), 1);
    chk("pulse4_steps", nsteps - base, 2);
    chk("pulse4_pos", 32'(position), 0);
    chk("pulse4_dir", 32'(dir), 0);

    // Error flag clear, set, and set racing a clear.
    eclr = 1'b1; tick(); eclr = 1'b0;
    chk("errclr", 32'(err), 0);
    {a, b} = 2'b11;
    repeat (10) tick();
    chk("illegal_err", 32'(err), 1);
    chk("illegal_pos", 32'(position), 0);
    eclr = 1'b1; tick(); eclr = 1'b0;
    chk("errclr2", 32'(err), 0);
    {a, b} = 2'b00;
    wait_filt(2'b00);
    eclr = 1'b1; tick(); eclr = 1'b0;
    chk("err_race", 32'(err), 1);
    tick();
    chk("err_hold", 32'(err), 1);

    // Wrap 0x7F -> 0x80, clear racing an edge, 0 -> 0xFF.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear_pos", 32'(position), 0);
    repeat (127) move(1, 8);
    chk("pos_7f", 32'(position), 32'h7f);
    move(1, 8);
    chk("pos_80", 32'(position), 32'h80);
    chk("pos_80_dir", 32'(dir), 1);
    base = nsteps;
    move(1, 0);
    wait_filt({a, b});
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_race_pos", 32'(position), 0);
    repeat (3) tick();
    chk("clr_race_step", nsteps - base, 1);
    move(3, 8);
    chk("pos_ff", 32'(position), 32'hff);
    chk("pos_ff_dir", 32'(dir), 0);

    // Random motion against a phase-arithmetic model.
    clr = 1'b1; eclr = 1'b1; tick(); clr = 1'b0; eclr = 1'b0;
    mpos = 0; merr = 1'b0; mdir = 1'b0; msteps = 0; base = nsteps;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(3) == 0) inv = ~inv;
      d = $urandom_range(3);
      if (d == 0 && $urandom_range(1) == 1) begin
        eclr = 1'b1; tick(); eclr = 1'b0;
        merr = 1'b0;
      end
      ph = ph_of(a, b);
      {a, b} = ab_of((ph + d) % 4);
      if (d == 1 || d == 3) begin
        mdir = (d == 1) ^ inv;
        mpos += mdir ? 1 : -1;
        msteps++;
      end else if (d == 2) begin
        merr = 1'b1;
      end
      repeat (9) tick();
      chk("rnd_pos", 32'(position), 32'(mpos & 8'hff));
      chk("rnd_dir", 32'(dir), 32'(mdir));
      chk("rnd_err", 32'(err), 32'(merr));
      chk("rnd_steps", nsteps - base, msteps);
    end
    inv = 1'b0;

`ifdef ENC_INDEX_EN
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (37) move(1, 8);
    chk("idx_pre_pos", 32'(position), 37);
    idx_zero = 1'b1;
    idx = 1'b1;
    repeat (10) tick();
    chk("idx_pos", 32'(idx_pos), 37);
    chk("idx_zeroed", 32'(position), 0);
    chk("idx_seen", 32'(idx_seen), 1);
    idx = 1'b0;
    idx_zero = 1'b0;
    repeat (10) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("idx_seen_clr", 32'(idx_seen), 0);
`endif

    // Reset in the middle of an edge in flight: nothing counts afterwards.
    clr = 1'b1; eclr = 1'b1; tick(); clr = 1'b0; eclr = 1'b0;
    base = nsteps;
    move(1, 3);
    resetn = 1'b0;
    move(1, 2);
    resetn = 1'b1;
    repeat (20) tick();
    chk("rst_mid_steps", nsteps - base, 0);
    chk("rst_mid_pos", 32'(position), 0);
    chk("rst_mid_err", 32'(err), 0);
    chk("rst_mid_filt", {30'd0, fa, fb}, {30'd0, a, b});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
